// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, parameter defaults and state encodings for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    localparam int DATA_BUS_WIDTH            = 8;
    localparam int INSTRUCTION_WIDTH         = 8;
    localparam int DEFAULT_ADDRESS_BUS_WIDTH = 8;
    localparam int DEFAULT_MEM_TIMEOUT       = 15;
    localparam int TMO_CNT_WIDTH             = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXECUTE = 3'd3;
    localparam logic [2:0] ST_HALTED  = 3'd4;
    localparam logic [2:0] ST_FAULT   = 3'd5;

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter register: load has priority over increment, arithmetic wraps modulo 2^W.
module fetch_sequencer_program_counter #(
    parameter int                           ADDRESS_BUS_WIDTH = 8,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] RESET_PC          = {ADDRESS_BUS_WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         inc,
    input  logic                         load,
    input  logic [ADDRESS_BUS_WIDTH-1:0] load_value,
    output logic [ADDRESS_BUS_WIDTH-1:0] pc_o
);

    logic [ADDRESS_BUS_WIDTH-1:0] pc_q;
    logic [ADDRESS_BUS_WIDTH-1:0] pc_d;

    // Next pc selection
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_value;
        end else if (inc) begin
            pc_d = pc_q + {{(ADDRESS_BUS_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            pc_d = pc_q;
        end
    end

    // pc register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute control FSM: drives the memory read handshake, the IR load enable,
// the execute start/done handshake and owns the program counter.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                           ADDRESS_BUS_WIDTH = DEFAULT_ADDRESS_BUS_WIDTH,
    parameter logic [ADDRESS_BUS_WIDTH-1:0] RESET_PC          = {ADDRESS_BUS_WIDTH{1'b0}},
    parameter int                           MEM_TIMEOUT       = DEFAULT_MEM_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    output logic                         mem_rd,
    output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
    input  logic                         mem_ack,
    output logic                         ir_en,
    output logic                         exec_start,
    input  logic                         exec_done,
    input  logic                         branch_valid,
    input  logic [ADDRESS_BUS_WIDTH-1:0] branch_target,
    input  logic                         halt,
    output logic [ADDRESS_BUS_WIDTH-1:0] pc,
    output logic [2:0]                   state,
    output logic                         halted,
    output logic                         fault
);

    // Counter value seen in the last allowed wait cycle; one more miss means fault.
    localparam logic [TMO_CNT_WIDTH-1:0] TMO_LAST = TMO_CNT_WIDTH'(MEM_TIMEOUT - 1);

    logic [2:0]                   state_q;
    logic [2:0]                   state_d;
    logic [TMO_CNT_WIDTH-1:0]     tmo_cnt_q;
    logic [TMO_CNT_WIDTH-1:0]     tmo_cnt_d;
    logic                         exec_start_q;
    logic                         exec_start_d;
    logic                         pc_inc_s;
    logic                         pc_load_s;
    logic [ADDRESS_BUS_WIDTH-1:0] pc_s;

    // Next-state, timeout counter and pc update decisions
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = {TMO_CNT_WIDTH{1'b0}};
        pc_inc_s  = 1'b0;
        pc_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    state_d = ST_DECODE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + {{(TMO_CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (exec_done) begin
                    if (halt) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_load_s = branch_valid;
                        pc_inc_s  = ~branch_valid;
                        state_d   = run ? ST_FETCH : ST_IDLE;
                    end
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        exec_start_d = (state_q == ST_DECODE);
    end

    // FSM, timeout counter and exec_start registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmo_cnt_q    <= {TMO_CNT_WIDTH{1'b0}};
            exec_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            exec_start_q <= exec_start_d;
        end
    end

    fetch_sequencer_program_counter #(
        .ADDRESS_BUS_WIDTH (ADDRESS_BUS_WIDTH),
        .RESET_PC          (RESET_PC)
    ) u_program_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (pc_inc_s),
        .load       (pc_load_s),
        .load_value (branch_target),
        .pc_o       (pc_s)
    );

    assign mem_rd     = (state_q == ST_FETCH);
    assign mem_addr   = mem_rd ? pc_s : {ADDRESS_BUS_WIDTH{1'b0}};
    assign ir_en      = mem_rd & mem_ack;
    assign exec_start = exec_start_q;
    assign pc         = pc_s;
    assign state      = state_q;
    assign halted     = (state_q == ST_HALTED);
    assign fault      = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer (W=8, RESET_PC=0, MEM_TIMEOUT=4).
module tb_fetch_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3, S_HALT = 3'd4, S_FAULT = 3'd5;

    logic       clk = 1'b0;
    logic       rst_n, run, mem_ack, exec_done, branch_valid, halt;
    logic [7:0] branch_target;
    logic       mem_rd, ir_en, exec_start, halted, fault;
    logic [7:0] mem_addr, pc;
    logic [2:0] state;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_sequencer #(
        .ADDRESS_BUS_WIDTH (8),
        .RESET_PC          (8'h00),
        .MEM_TIMEOUT       (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .ir_en         (ir_en),
        .exec_start    (exec_start),
        .exec_done     (exec_done),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt          (halt),
        .pc            (pc),
        .state         (state),
        .halted        (halted),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; mem_ack = 1'b1; exec_done = 1'b0;
        branch_valid = 1'b0; branch_target = 8'h00; halt = 1'b0;
        step(); step(); #1;
        expect_eq("rst_state", 32'(state), 32'(S_IDLE));
        expect_eq("rst_pc", 32'(pc), 32'h0);
        expect_eq("rst_mem_rd", 32'(mem_rd), 32'h0);
        expect_eq("rst_ir_en", 32'(ir_en), 32'h0);
        expect_eq("rst_exec_start", 32'(exec_start), 32'h0);
        expect_eq("rst_halted", 32'(halted), 32'h0);
        expect_eq("rst_fault", 32'(fault), 32'h0);

        // 1: zero-wait memory, three instructions at 3 cycles each
        rst_n = 1'b1; run = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); exec_done = 1'b0; mem_ack = 1'b1; #1;
            expect_eq("t1_fetch_state", 32'(state), 32'(S_FETCH));
            expect_eq("t1_mem_rd", 32'(mem_rd), 32'h1);
            expect_eq("t1_mem_addr", 32'(mem_addr), 32'(i));
            expect_eq("t1_ir_en", 32'(ir_en), 32'h1);
            step(); mem_ack = 1'b0; #1;
            expect_eq("t1_decode_state", 32'(state), 32'(S_DECODE));
            expect_eq("t1_decode_ir_en", 32'(ir_en), 32'h0);
            expect_eq("t1_decode_mem_rd", 32'(mem_rd), 32'h0);
            expect_eq("t1_decode_exec_start", 32'(exec_start), 32'h0);
            step(); exec_done = 1'b1; #1;
            expect_eq("t1_exec_state", 32'(state), 32'(S_EXEC));
            expect_eq("t1_exec_start", 32'(exec_start), 32'h1);
        end

        // 2: three wait states, then a taken branch
        for (int k = 0; k < 4; k++) begin
            step(); exec_done = 1'b0; mem_ack = (k == 3); #1;
            expect_eq("t2_mem_rd", 32'(mem_rd), 32'h1);
            expect_eq("t2_mem_addr", 32'(mem_addr), 32'h3);
            expect_eq("t2_ir_en", 32'(ir_en), 32'(k == 3));
            expect_eq("t2_no_fault", 32'(fault), 32'h0);
        end
        step(); mem_ack = 1'b0; #1;
        expect_eq("t2_decode", 32'(state), 32'(S_DECODE));
        step(); exec_done = 1'b1; branch_valid = 1'b1; branch_target = 8'h40; #1;
        expect_eq("t2_exec_start", 32'(exec_start), 32'h1);
        step(); exec_done = 1'b0; branch_valid = 1'b0; mem_ack = 1'b1; #1;
        expect_eq("t2_branch_state", 32'(state), 32'(S_FETCH));
        expect_eq("t2_branch_addr", 32'(mem_addr), 32'h40);

        // 3: branch to 0xFF, wrap to 0x00, then halt beats branch
        step(); mem_ack = 1'b0;
        step(); exec_done = 1'b1; branch_valid = 1'b1; branch_target = 8'hFF;
        step(); exec_done = 1'b0; branch_valid = 1'b0; mem_ack = 1'b1; #1;
        expect_eq("t3_pc_ff", 32'(pc), 32'hFF);
        step(); mem_ack = 1'b0;
        step(); #1;
        expect_eq("t3_exec_start_first", 32'(exec_start), 32'h1);
        step(); exec_done = 1'b1; #1;
        expect_eq("t3_exec_second_state", 32'(state), 32'(S_EXEC));
        expect_eq("t3_exec_start_second", 32'(exec_start), 32'h0);
        step(); exec_done = 1'b0; mem_ack = 1'b1; #1;
        expect_eq("t3_wrap_pc", 32'(pc), 32'h00);
        expect_eq("t3_wrap_addr", 32'(mem_addr), 32'h00);
        step(); mem_ack = 1'b0;
        step(); exec_done = 1'b1; halt = 1'b1; branch_valid = 1'b1; branch_target = 8'h55;
        step(); exec_done = 1'b0; halt = 1'b0; branch_valid = 1'b0; mem_ack = 1'b1; #1;
        expect_eq("t3_halt_state", 32'(state), 32'(S_HALT));
        expect_eq("t3_halted", 32'(halted), 32'h1);
        expect_eq("t3_halt_pc", 32'(pc), 32'h00);
        expect_eq("t3_halt_mem_rd", 32'(mem_rd), 32'h0);
        expect_eq("t3_halt_ir_en", 32'(ir_en), 32'h0);
        step(); exec_done = 1'b1; #1;
        expect_eq("t3_halt_sticky", 32'(state), 32'(S_HALT));
        expect_eq("t3_halt_sticky_rd", 32'(mem_rd), 32'h0);

        // 4a: timeout with mem_ack held low
        exec_done = 1'b0; mem_ack = 1'b0; rst_n = 1'b0;
        step(); rst_n = 1'b1; #1;
        expect_eq("t4_reset_state", 32'(state), 32'(S_IDLE));
        expect_eq("t4_reset_halted", 32'(halted), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step(); #1;
            expect_eq("t4_wait_state", 32'(state), 32'(S_FETCH));
            expect_eq("t4_wait_fault", 32'(fault), 32'h0);
        end
        step(); mem_ack = 1'b1; #1;
        expect_eq("t4_fault_state", 32'(state), 32'(S_FAULT));
        expect_eq("t4_fault", 32'(fault), 32'h1);
        expect_eq("t4_fault_mem_rd", 32'(mem_rd), 32'h0);
        expect_eq("t4_fault_ir_en", 32'(ir_en), 32'h0);
        step(); #1;
        expect_eq("t4_fault_sticky", 32'(state), 32'(S_FAULT));

        // 4b: mem_ack in the expiry cycle wins
        mem_ack = 1'b0; rst_n = 1'b0;
        step(); rst_n = 1'b1; #1;
        expect_eq("t4b_reset_fault", 32'(fault), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step(); mem_ack = (k == 4); #1;
            expect_eq("t4b_state", 32'(state), 32'(S_FETCH));
            expect_eq("t4b_ir_en", 32'(ir_en), 32'(k == 4));
        end
        step(); mem_ack = 1'b0; #1;
        expect_eq("t4b_decode", 32'(state), 32'(S_DECODE));
        expect_eq("t4b_no_fault", 32'(fault), 32'h0);

        // 5: reset mid-fetch, late ack in IDLE ignored
        step(); exec_done = 1'b1;
        step(); exec_done = 1'b0; #1;
        expect_eq("t5_fetch_addr", 32'(mem_addr), 32'h1);
        rst_n = 1'b0;
        step(); rst_n = 1'b1; run = 1'b0; mem_ack = 1'b1; #1;
        expect_eq("t5_state", 32'(state), 32'(S_IDLE));
        expect_eq("t5_pc", 32'(pc), 32'h0);
        expect_eq("t5_ir_en", 32'(ir_en), 32'h0);
        expect_eq("t5_mem_rd", 32'(mem_rd), 32'h0);
        step(); mem_ack = 1'b0; #1;
        expect_eq("t5_idle_hold", 32'(state), 32'(S_IDLE));

        // 6: run dropped mid-instruction takes effect only at exec_done
        run = 1'b1;
        step(); mem_ack = 1'b1; #1;
        expect_eq("t6_fetch_latency", 32'(mem_rd), 32'h1);
        step(); mem_ack = 1'b0; run = 1'b0;
        step(); exec_done = 1'b1; #1;
        expect_eq("t6_exec_no_abort", 32'(state), 32'(S_EXEC));
        step(); exec_done = 1'b0; #1;
        expect_eq("t6_idle_state", 32'(state), 32'(S_IDLE));
        expect_eq("t6_idle_pc", 32'(pc), 32'h1);
        expect_eq("t6_idle_mem_rd", 32'(mem_rd), 32'h0);
        run = 1'b1;
        step(); #1;
        expect_eq("t6_refetch_state", 32'(state), 32'(S_FETCH));
        expect_eq("t6_refetch_addr", 32'(mem_addr), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
